// File: rtl/vga_pixel_stream_pkg.sv
// Display mode constants shared by the pixel stream and its counters.
package vga_pixel_stream_pkg;

  localparam int VGA_MODE_H_VISIBLE = 640;
  localparam int VGA_MODE_V_VISIBLE = 480;
  localparam int VGA_MODE_H_TOTAL   = 800;
  localparam int VGA_MODE_V_TOTAL   = 525;

  // A one-entry range still needs a one-bit counter.
  function automatic int bits_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_pixel_stream_counter.sv
// Wrapping position counter: async reset, sync clear, counts 0..LIMIT-1.
module vga_pixel_stream_counter #(
  parameter int LIMIT = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             step,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  assign wrap = (count == WIDTH'(LIMIT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (step) begin
      count <= wrap ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/vga_pixel_stream.sv
// Visible-region pixel walker emitting column/row/address beats on a
// valid/ready stream. VGA_PIXEL_STREAM_SCALE2_EN enables 2x pixel doubling.
module vga_pixel_stream
  import vga_pixel_stream_pkg::*;
#(
  parameter int H_VISIBLE   = VGA_MODE_H_VISIBLE,
  parameter int V_VISIBLE   = VGA_MODE_V_VISIBLE,
  parameter int ADDR_BITS   = 20,
  parameter int STRIDE      = H_VISIBLE,
  parameter int BASE_ADDR   = 0,
  localparam int COLUMN_BITS = bits_for(H_VISIBLE),
  localparam int ROW_BITS    = bits_for(V_VISIBLE)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   restart,
  input  logic                   ready,
  output logic                   valid,
  output logic [COLUMN_BITS-1:0] column,
  output logic [ROW_BITS-1:0]    row,
  output logic [ADDR_BITS-1:0]   addr,
  output logic                   first,
  output logic                   last_col,
  output logic                   last
);

  localparam logic [ADDR_BITS-1:0] BASE = ADDR_BITS'(BASE_ADDR);
  localparam logic [ADDR_BITS-1:0] STEP = ADDR_BITS'(STRIDE);
  localparam logic [COLUMN_BITS-1:0] COL_MAX = COLUMN_BITS'(H_VISIBLE - 1);
  localparam logic [ROW_BITS-1:0] ROW_MAX = ROW_BITS'(V_VISIBLE - 1);

  logic                   advance;
  logic                   col_wrap;
  logic                   row_wrap;
  logic [COLUMN_BITS-1:0] next_col;
  logic [ROW_BITS-1:0]    next_row;
  logic [ADDR_BITS-1:0]   line_base;
  logic [ADDR_BITS-1:0]   next_base;
  logic [ADDR_BITS-1:0]   next_addr;

  assign advance = valid & ready & ~restart;

  vga_pixel_stream_counter #(
    .LIMIT(H_VISIBLE),
    .WIDTH(COLUMN_BITS)
  ) col_cnt (
    .clk  (clk),
    .reset(reset),
    .clear(restart),
    .step (advance),
    .count(column),
    .wrap (col_wrap)
  );

  vga_pixel_stream_counter #(
    .LIMIT(V_VISIBLE),
    .WIDTH(ROW_BITS)
  ) row_cnt (
    .clk  (clk),
    .reset(reset),
    .clear(restart),
    .step (advance & last_col),
    .count(row),
    .wrap (row_wrap)
  );

  // Position after this beat, used to register the markers with it.
  always_comb begin
    next_col = col_wrap ? '0 : column + COLUMN_BITS'(1);
    next_row = row;
    if (col_wrap) begin
      next_row = row_wrap ? '0 : row + ROW_BITS'(1);
    end
  end

  always_comb begin
    next_base = line_base;
`ifdef VGA_PIXEL_STREAM_SCALE2_EN
    next_addr = addr + ADDR_BITS'(column[0]);
`else
    next_addr = addr + ADDR_BITS'(1);
`endif
    if (last) begin
      next_base = BASE;
      next_addr = BASE;
    end else if (last_col) begin
`ifdef VGA_PIXEL_STREAM_SCALE2_EN
      if (row[0]) begin
        next_base = line_base + STEP;
      end
`else
      next_base = line_base + STEP;
`endif
      next_addr = next_base;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid     <= 1'b0;
      addr      <= BASE;
      line_base <= BASE;
      first     <= 1'b1;
      last_col  <= 1'b0;
      last      <= 1'b0;
    end else if (restart) begin
      valid     <= 1'b0;
      addr      <= BASE;
      line_base <= BASE;
      first     <= 1'b1;
      last_col  <= 1'b0;
      last      <= 1'b0;
    end else if (valid & ready) begin
      valid     <= enable;
      addr      <= next_addr;
      line_base <= next_base;
      first     <= (next_col == '0) && (next_row == '0);
      last_col  <= (next_col == COL_MAX);
      last      <= (next_col == COL_MAX) && (next_row == ROW_MAX);
    end else if (!valid) begin
      valid <= enable;
    end
  end

endmodule

// File: tb/tb_vga_pixel_stream.sv
// Scoreboard bench for vga_pixel_stream on a 4x3 mode, stride 8, base 16.
`timescale 1ns/1ps
module tb_vga_pixel_stream;

  localparam int H      = 4;
  localparam int V      = 3;
  localparam int STRIDE = 8;
  localparam int BASE   = 16;
  localparam int AB     = 20;

  typedef struct packed {
    logic [1:0]    col;
    logic [1:0]    row;
    logic [AB-1:0] addr;
    logic          first;
    logic          last_col;
    logic          last;
  } beat_t;

  logic          clk;
  logic          reset;
  logic          enable;
  logic          restart;
  logic          ready;
  logic          valid;
  logic [1:0]    column;
  logic [1:0]    row;
  logic [AB-1:0] addr;
  logic          first;
  logic          last_col;
  logic          last;

  int tests;
  int fails;

  beat_t q[$];
  beat_t cur;
  beat_t held;
  beat_t exp_b;
  bit    hold;

  vga_pixel_stream #(
    .H_VISIBLE(H),
    .V_VISIBLE(V),
    .ADDR_BITS(AB),
    .STRIDE   (STRIDE),
    .BASE_ADDR(BASE)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .restart (restart),
    .ready   (ready),
    .valid   (valid),
    .column  (column),
    .row     (row),
    .addr    (addr),
    .first   (first),
    .last_col(last_col),
    .last    (last)
  );

  always #5 clk = ~clk;

  // k-th beat after (0,0), straight from the frame geometry.
  function automatic beat_t model(int k);
    beat_t b;
    int c;
    int r;
    int a;
    c = k % H;
    r = (k / H) % V;
`ifdef VGA_PIXEL_STREAM_SCALE2_EN
    a = BASE + (r / 2) * STRIDE + c / 2;
`else
    a = BASE + r * STRIDE + c;
`endif
    b.col      = 2'(c);
    b.row      = 2'(r);
    b.addr     = AB'(a);
    b.first    = (c == 0) && (r == 0);
    b.last_col = (c == H - 1);
    b.last     = (c == H - 1) && (r == V - 1);
    return b;
  endfunction

  task automatic load_sb();
    q.delete();
    for (int k = 0; k < 800; k++) q.push_back(model(k));
  endtask

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(string name);
    chk({name, "_valid"}, int'(valid), 0);
    chk({name, "_column"}, int'(column), 0);
    chk({name, "_row"}, int'(row), 0);
    chk({name, "_addr"}, int'(addr), BASE);
    chk({name, "_first"}, int'(first), 1);
    chk({name, "_last_col"}, int'(last_col), 0);
    chk({name, "_last"}, int'(last), 0);
  endtask

  task automatic wait_pos(int c, int r, string name);
    int i;
    i = 0;
    while (!(valid && column == c && row == r) && i < 60) begin
      step(1);
      i++;
    end
    chk({name, "_found"}, int'(valid && column == c && row == r), 1);
  endtask

  // Monitor: pops on every transfer, and checks held beats stay frozen.
  always @(negedge clk) begin
    cur = {column, row, addr, first, last_col, last};
    if (reset || restart) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        tests++;
        if (!valid || cur != held) begin
          fails++;
          $display("FAIL hold_stable: got valid=%0b addr=%0d col=%0d row=%0d, expected valid=1 addr=%0d col=%0d row=%0d",
                   valid, addr, column, row, held.addr, held.col, held.row);
        end
      end
      if (valid && ready) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL sb_empty: got beat addr=%0d, expected no beat", addr);
        end else begin
          exp_b = q.pop_front();
          if (cur != exp_b) begin
            fails++;
            $display("FAIL beat: got col=%0d row=%0d addr=%0d f=%0b lc=%0b l=%0b, expected col=%0d row=%0d addr=%0d f=%0b lc=%0b l=%0b",
                     column, row, addr, first, last_col, last,
                     exp_b.col, exp_b.row, exp_b.addr,
                     exp_b.first, exp_b.last_col, exp_b.last);
          end
        end
      end
      hold = valid && !ready;
      held = cur;
    end
  end

  initial begin
    beat_t m;
    tests   = 0;
    fails   = 0;
    hold    = 1'b0;
    clk     = 1'b0;
    reset   = 1'b1;
    enable  = 1'b0;
    restart = 1'b0;
    ready   = 1'b0;
    step(2);
    chk_reset_state("reset");

    reset = 1'b0;
    load_sb();
    step(1);
    enable = 1'b1;
    ready  = 1'b1;
    chk("latency_pre", int'(valid), 0);
    step(1);
    chk("latency_valid", int'(valid), 1);
    chk("latency_addr", int'(addr), int'(model(0).addr));
    step(12);
    chk("wrap_addr", int'(addr), int'(model(12).addr));
    chk("wrap_first", int'(first), 1);

    // Backpressure at (2,1)
    wait_pos(2, 1, "bp");
    ready = 1'b0;
    m = model(6);
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("bp_valid", int'(valid), 1);
      chk("bp_addr", int'(addr), int'(m.addr));
      chk("bp_column", int'(column), 2);
      chk("bp_row", int'(row), 1);
    end
    ready = 1'b1;
    step(1);
    chk("bp_next_addr", int'(addr), int'(model(7).addr));
    chk("bp_next_last_col", int'(last_col), 1);

    // Enable drop while (1,0) is pending
    wait_pos(1, 0, "en");
    ready  = 1'b0;
    enable = 1'b0;
    step(3);
    chk("en_hold_valid", int'(valid), 1);
    chk("en_hold_addr", int'(addr), int'(model(1).addr));
    ready = 1'b1;
    step(1);
    chk("en_drop_valid", int'(valid), 0);
    chk("en_drop_addr", int'(addr), int'(model(2).addr));
    enable = 1'b1;
    step(1);
    chk("en_resume_valid", int'(valid), 1);
    chk("en_resume_addr", int'(addr), int'(model(2).addr));

    // Restart colliding with a transfer at (1,2)
    wait_pos(1, 2, "rs");
    restart = 1'b1;
    load_sb();
    step(1);
    restart = 1'b0;
    chk("rs_valid", int'(valid), 0);
    chk("rs_addr", int'(addr), BASE);
    chk("rs_first", int'(first), 1);
    chk("rs_column", int'(column), 0);
    step(1);
    chk("rs_beat_valid", int'(valid), 1);
    chk("rs_beat_addr", int'(addr), BASE);
    chk("rs_beat_first", int'(first), 1);

    // Asynchronous reset between edges
    step(5);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_state("async");
    load_sb();
    step(1);
    reset = 1'b0;
    step(1);
    chk("async_rel_valid", int'(valid), 1);
    chk("async_rel_addr", int'(addr), BASE);

    // Random handshake traffic with occasional restarts
    for (int i = 0; i < 500; i++) begin
      ready   = ($urandom_range(0, 3) != 0);
      enable  = ($urandom_range(0, 7) != 0);
      restart = ($urandom_range(0, 99) == 0);
      if (restart) load_sb();
      step(1);
    end
    restart = 1'b0;
    ready   = 1'b0;
    enable  = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
